// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : score_keeper
// Description : Saturating game score with session high score, plus a
//               request/acknowledge handshake to an external binary-to-BCD
//               converter that feeds the display.
// Revision    : 1.0 - initial release
// ============================================================================
module score_keeper #(
  parameter logic [11:0] MAX_SCORE    = 12'd4095,
  parameter int          CONV_TIMEOUT = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        run,
  input  logic        eat_tick,
  input  logic [3:0]  points,
  input  logic        penalty_tick,
  input  logic        conv_rdy,
  input  logic [15:0] conv_bcd,
  output logic        conv_en,
  output logic [11:0] conv_bin,
  output logic [11:0] score,
  output logic [11:0] high_score,
  output logic [15:0] disp_bcd,
  output logic        new_high,
  output logic        busy
);

  localparam int                 c_cnt_w    = $clog2(CONV_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CONV_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [11:0]         r_score;
  logic [11:0]         r_high;
  logic [11:0]         r_conv_bin;
  logic [15:0]         r_disp;
  logic                r_new_high;
  logic                r_dirty;
  logic [c_cnt_w-1:0]  r_cnt;

  logic [12:0]         w_sum;
  logic [12:0]         w_raw;
  logic [11:0]         w_score_nxt;
  logic                w_changed;
  logic                w_high_up;
  logic                w_timeout;
  logic                w_conv_done;
  logic                w_dirty_nxt;

  // Score arithmetic is done 13 bits wide so the ceiling clamp sees overflow.
  always_comb begin
    w_sum = {1'b0, r_score} + {9'd0, points};
    w_raw = {1'b0, r_score};
    if (run) begin
      if (eat_tick && penalty_tick) begin
        w_raw = (w_sum == 13'd0) ? 13'd0 : (w_sum - 13'd1);
      end else if (eat_tick) begin
        w_raw = w_sum;
      end else if (penalty_tick) begin
        w_raw = (r_score == 12'd0) ? 13'd0 : ({1'b0, r_score} - 13'd1);
      end
    end
    if (clear) begin
      w_score_nxt = 12'd0;
    end else if (w_raw > {1'b0, MAX_SCORE}) begin
      w_score_nxt = MAX_SCORE;
    end else begin
      w_score_nxt = w_raw[11:0];
    end
  end

  assign w_changed = (w_score_nxt != r_score);
  assign w_high_up = (w_score_nxt > r_high);

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_conv_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_dirty) begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (conv_rdy) begin
          w_conv_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == c_cnt_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The request in SEND consumes dirty; a same-cycle score change re-arms it.
  assign w_dirty_nxt = ((r_state == ST_SEND) ? 1'b0 : r_dirty)
                       | w_changed | clear | w_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_score    <= 12'd0;
      r_high     <= 12'd0;
      r_conv_bin <= 12'd0;
      r_disp     <= 16'h0000;
      r_new_high <= 1'b0;
      r_dirty    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_score    <= w_score_nxt;
      r_dirty    <= w_dirty_nxt;
      r_new_high <= w_high_up;
      if (w_high_up) begin
        r_high <= w_score_nxt;
      end
      // Loaded on entry to SEND so it already equals score while conv_en is high.
      if ((r_state == ST_IDLE) && r_dirty) begin
        r_conv_bin <= w_score_nxt;
      end
      if (w_conv_done) begin
        r_disp <= conv_bcd;
      end
      if ((r_state == ST_WAIT) && (w_state_nxt == ST_WAIT)) begin
        r_cnt <= r_cnt + c_cnt_one;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign conv_en    = (r_state == ST_SEND);
  assign busy       = (r_state != ST_IDLE);
  assign conv_bin   = r_conv_bin;
  assign score      = r_score;
  assign high_score = r_high;
  assign disp_bcd   = r_disp;
  assign new_high   = r_new_high;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_keeper
// Description : Directed bench for score_keeper with a cycle model and a
//               configurable-latency converter responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

  localparam int TMO  = 127;
  localparam int SMAX = 4095;

  logic        clk = 1'b0;
  logic        reset, clear, run, eat_tick, penalty_tick;
  logic [3:0]  points;
  logic        conv_rdy = 1'b0;
  logic [15:0] conv_bcd = 16'hDEAD;
  logic        conv_en, new_high, busy;
  logic [11:0] conv_bin, score, high_score;
  logic [15:0] disp_bcd;

  always #5 clk = ~clk;

  score_keeper #(.MAX_SCORE(12'd4095), .CONV_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .clear(clear), .run(run),
    .eat_tick(eat_tick), .points(points), .penalty_tick(penalty_tick),
    .conv_rdy(conv_rdy), .conv_bcd(conv_bcd), .conv_en(conv_en),
    .conv_bin(conv_bin), .score(score), .high_score(high_score),
    .disp_bcd(disp_bcd), .new_high(new_high), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input logic [11:0] v);
    int x;
    x = int'(v);
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  // Converter stand-in: answers resp_delay cycles after conv_en, 0 = never.
  int          resp_delay = 3;
  int          resp_cnt   = 0;
  logic [11:0] resp_val   = 12'd0;
  always @(negedge clk) begin
    conv_rdy = 1'b0;
    conv_bcd = 16'hDEAD;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        conv_rdy = 1'b1;
        conv_bcd = to_bcd(resp_val);
      end
    end
    if (conv_en === 1'b1 && resp_delay > 0) begin
      resp_val = conv_bin;
      resp_cnt = resp_delay;
    end
  end

  // Model: score by integer clamp; conversion as send flag + remaining wait budget.
  int          m_score, m_high, m_wait_left;
  bit          m_newhigh, m_dirty, m_send;
  bit          m_valid = 1'b0;
  logic [15:0] m_disp;
  logic [11:0] m_bin;
  int          cyc_n = 0, en_count = 0, nh_count = 0, last_en_cyc = 0, en_gap = 0;
  logic [11:0] last_en_bin = 12'd0;

  always @(posedge clk) begin
    int s;
    bit touch;
    cyc_n++;
    if (reset) begin
      m_score = 0; m_high = 0; m_wait_left = 0; m_newhigh = 0;
      m_dirty = 0; m_send = 0; m_disp = 16'h0000; m_bin = 12'd0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      s = m_score;
      if (clear) begin
        s = 0;
      end else if (run) begin
        s = m_score + (eat_tick ? int'(points) : 0) - (penalty_tick ? 1 : 0);
        if (s < 0) s = 0;
        if (s > SMAX) s = SMAX;
      end
      touch = (s != m_score) || clear;
      m_newhigh = (s > m_high);
      if (m_newhigh) m_high = s;
      if (m_send) begin
        m_send      = 0;
        m_bin       = 12'(m_score);
        m_wait_left = TMO;
        m_dirty     = touch;
      end else if (m_wait_left > 0) begin
        if (conv_rdy) begin
          m_disp      = conv_bcd;
          m_wait_left = 0;
        end else begin
          m_wait_left--;
          if (m_wait_left == 0) m_dirty = 1;
        end
        if (touch) m_dirty = 1;
      end else begin
        if (m_dirty) m_send = 1;
        if (touch) m_dirty = 1;
      end
      m_score = s;
    end
    #1;
    if (m_valid) begin
      chk("score", 32'(score), 32'(m_score));
      chk("high_score", 32'(high_score), 32'(m_high));
      chk("new_high", 32'(new_high), 32'(m_newhigh));
      chk("conv_en", 32'(conv_en), 32'(m_send));
      chk("busy", 32'(busy), 32'(m_send || m_wait_left > 0));
      chk("disp_bcd", 32'(disp_bcd), 32'(m_disp));
      if (m_send) chk("conv_bin_send", 32'(conv_bin), 32'(m_score));
      else if (m_wait_left > 0) chk("conv_bin_wait", 32'(conv_bin), 32'(m_bin));
      if (conv_en === 1'b1) begin
        en_count++;
        en_gap      = cyc_n - last_en_cyc;
        last_en_cyc = cyc_n;
        last_en_bin = conv_bin;
      end
      if (new_high === 1'b1) nh_count++;
    end
  end

  task automatic tick(input bit c, input bit e, input bit p, input logic [3:0] pts);
    clear = c; eat_tick = e; penalty_tick = p; points = pts;
    @(negedge clk);
    clear = 1'b0; eat_tick = 1'b0; penalty_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < 600) begin
      @(negedge clk);
      n++;
      if (busy === 1'b0) quiet++;
      else quiet = 0;
    end
    chk("settle", 32'(quiet >= 3), 32'd1);
  endtask

  int e0;

  initial begin
    reset = 1'b1; clear = 1'b0; run = 1'b0;
    eat_tick = 1'b0; penalty_tick = 1'b0; points = 4'd0;
    @(negedge clk); @(negedge clk);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_high", 32'(high_score), 32'd0);
    chk("rst_disp", 32'(disp_bcd), 32'h0);
    chk("rst_conv_bin", 32'(conv_bin), 32'd0);
    chk("rst_conv_en", 32'(conv_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_new_high", 32'(new_high), 32'd0);
    reset = 1'b0;

    // Three eats of 5
    run = 1'b1; resp_delay = 3; nh_count = 0;
    repeat (3) tick(1'b0, 1'b1, 1'b0, 4'd5);
    wait_idle();
    chk("s1_score", 32'(score), 32'd15);
    chk("s1_high", 32'(high_score), 32'd15);
    chk("s1_disp", 32'(disp_bcd), 32'h0015);
    chk("s1_new_high_pulses", 32'(nh_count), 32'd3);

    // Ticks ignored while not running
    run = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 4'd5);
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    idle(2);
    chk("run_low_score", 32'(score), 32'd15);
    run = 1'b1;

    // Climb to 4093, then saturate
    repeat (271) tick(1'b0, 1'b1, 1'b0, 4'd15);
    tick(1'b0, 1'b1, 1'b0, 4'd13);
    wait_idle();
    chk("s3_score_4093", 32'(score), 32'd4093);
    tick(1'b0, 1'b1, 1'b0, 4'd9);
    chk("s3_saturate", 32'(score), 32'd4095);
    tick(1'b0, 1'b1, 1'b0, 4'd15);
    chk("s3_hold_max", 32'(score), 32'd4095);
    chk("s3_high", 32'(high_score), 32'd4095);
    wait_idle();
    chk("s3_disp", 32'(disp_bcd), 32'h4095);

    // Floor at zero
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    wait_idle();
    chk("clr_score", 32'(score), 32'd0);
    chk("clr_keep_high", 32'(high_score), 32'd4095);
    chk("clr_disp", 32'(disp_bcd), 32'h0000);
    e0 = en_count;
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    tick(1'b0, 1'b1, 1'b1, 4'd0);
    idle(4);
    chk("floor_score", 32'(score), 32'd0);
    chk("floor_no_conv", 32'(en_count - e0), 32'd0);

    // Simultaneous eat+penalty
    tick(1'b0, 1'b1, 1'b0, 4'd3);
    wait_idle();
    e0 = en_count;
    tick(1'b0, 1'b1, 1'b1, 4'd1);
    idle(5);
    chk("both_p1_score", 32'(score), 32'd3);
    chk("both_p1_no_conv", 32'(en_count - e0), 32'd0);
    tick(1'b0, 1'b1, 1'b1, 4'd9);
    wait_idle();
    chk("both_p9_score", 32'(score), 32'd11);
    chk("both_p9_disp", 32'(disp_bcd), 32'h0011);

    // Score change while waiting on the converter
    resp_delay = 10; e0 = en_count;
    tick(1'b0, 1'b1, 1'b0, 4'd5);
    idle(4);
    tick(1'b0, 1'b1, 1'b0, 4'd7);
    wait_idle();
    chk("s5_conv_count", 32'(en_count - e0), 32'd2);
    chk("s5_last_bin", 32'(last_en_bin), 32'd23);
    chk("s5_disp", 32'(disp_bcd), 32'h0023);

    // Converter silent: timeout and retry
    resp_delay = 0; e0 = en_count;
    tick(1'b0, 1'b1, 1'b0, 4'd1);
    idle(140);
    chk("s6_retry_seen", 32'(en_count - e0), 32'd2);
    chk("s6_retry_gap", 32'(en_gap), 32'd129);
    chk("s6_disp_kept", 32'(disp_bcd), 32'h0023);
    resp_delay = 3;
    wait_idle();
    chk("s6_disp_final", 32'(disp_bcd), 32'h0024);

    // Reset in the middle of a wait; late conv_rdy must be ignored
    resp_delay = 10;
    tick(1'b0, 1'b1, 1'b0, 4'd1);
    idle(4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(15);
    chk("s7_disp", 32'(disp_bcd), 32'h0000);
    chk("s7_score", 32'(score), 32'd0);
    chk("s7_busy", 32'(busy), 32'd0);

    // score=42, high=80, then clear
    resp_delay = 3;
    repeat (5) tick(1'b0, 1'b1, 1'b0, 4'd15);
    tick(1'b0, 1'b1, 1'b0, 4'd5);
    wait_idle();
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    repeat (2) tick(1'b0, 1'b1, 1'b0, 4'd15);
    tick(1'b0, 1'b1, 1'b0, 4'd12);
    wait_idle();
    chk("s8_score", 32'(score), 32'd42);
    chk("s8_high", 32'(high_score), 32'd80);
    chk("s8_disp42", 32'(disp_bcd), 32'h0042);
    resp_delay = 10;
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    chk("s8_clr_score", 32'(score), 32'd0);
    chk("s8_clr_high", 32'(high_score), 32'd80);
    wait_idle();
    chk("s8_disp0", 32'(disp_bcd), 32'h0000);

    // Clear while a conversion is in flight
    tick(1'b0, 1'b1, 1'b0, 4'd7);
    idle(4);
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    wait_idle();
    chk("s9_disp0", 32'(disp_bcd), 32'h0000);
    chk("s9_high", 32'(high_score), 32'd80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter MAX_SCORE, default 12'd4095: saturation ceiling for score.
REQ-002 Parameter CONV_TIMEOUT, default 127: cycles in WAIT before abandoning a conversion.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 clear  in  1  new-game clear; zeroes score, keeps high_score.
REQ-006 run  in  1  game running; score events are ignored when low.
REQ-007 eat_tick  in  1  one-cycle pulse; add points to score.
REQ-008 points  in  4  unsigned value added per eat_tick.
REQ-009 penalty_tick  in  1  one-cycle pulse; subtract 1 from score.
REQ-010 conv_rdy  in  1  one-cycle done pulse from the downstream binary-to-BCD converter.
REQ-011 conv_bcd  in  16  converter result, 4 BCD digits; valid only while conv_rdy=1.
REQ-012 conv_en  out  1  one-cycle conversion request to the converter.
REQ-013 conv_bin  out  12  binary value to convert.
REQ-014 score  out  12  current score, binary.
REQ-015 high_score  out  12  session best, binary.
REQ-016 disp_bcd  out  16  last converted score, fed to the 7-segment driver.
REQ-017 new_high  out  1  one-cycle pulse when high_score increases.
REQ-018 busy  out  1  high whenever the conversion FSM is not in IDLE.

Function
REQ-019 Event priority SHALL be reset > clear > run-gated ticks; when run=0, ticks SHALL be ignored.
REQ-020 eat_tick alone SHALL set score = min(score+points, MAX_SCORE); the sum SHALL be computed in 13 bits before the clamp.
REQ-021 penalty_tick alone SHALL set score = max(score-1, 0); at score=0 it SHALL leave score unchanged.
REQ-022 When eat_tick and penalty_tick occur together, score SHALL change by points-1 in a single step, with a 0 floor and a MAX_SCORE ceiling.
REQ-023 clear SHALL set score=0 on the next edge, SHALL leave high_score unchanged, and SHALL set the dirty flag.
REQ-024 When the next score value is greater than high_score, high_score SHALL load it on the same edge and new_high SHALL pulse for exactly 1 cycle.
REQ-025 A dirty flag SHALL be set on every edge where score changes value, and on clear.
REQ-026 The conversion FSM SHALL have three states: IDLE, SEND and WAIT.
REQ-027 In IDLE, if dirty=1, the FSM SHALL go to SEND; otherwise it SHALL stay in IDLE.
REQ-028 In SEND, the block SHALL:
  - assert conv_en for exactly 1 cycle;
  - load conv_bin with the current score;
  - clear dirty, unless score changes in that same cycle, in which case dirty SHALL stay 1;
  - go to WAIT.
REQ-029 In WAIT, conv_bin SHALL be held stable, conv_en SHALL be 0, and a timeout counter SHALL increment each cycle.
REQ-030 In WAIT, conv_rdy=1 SHALL load disp_bcd from conv_bcd, clear the counter and return the FSM to IDLE.
REQ-031 In WAIT, when the counter reaches CONV_TIMEOUT, the FSM SHALL return to IDLE, set dirty to force a retry, and leave disp_bcd unchanged.
REQ-032 conv_rdy SHALL be ignored in IDLE and SEND.
REQ-033 Score changes during WAIT SHALL set dirty only; the block SHALL NOT issue conv_en until the FSM is back in IDLE.
REQ-034 Latency SHALL be 2 cycles from a score change in IDLE to conv_en (1 edge sets dirty, 1 to enter SEND).
REQ-035 With the 12-bit shift-add converter, conv_rdy is expected 62-66 cycles after conv_en, which is within the CONV_TIMEOUT default.

Reset
REQ-036 On reset the block SHALL set:
  - score=0, high_score=0, disp_bcd=16'h0000;
  - conv_en=0, conv_bin=0, new_high=0, busy=0;
  - dirty=0, timeout counter=0, FSM state=IDLE.
REQ-037 Reset asserted mid-WAIT SHALL abandon the conversion; a conv_rdy arriving after reset SHALL be ignored.
REQ-038 clear SHALL NOT affect the FSM state; a conversion in flight SHALL complete, and the zero score SHALL be converted next.

Verification
REQ-039 Scenario: run=1, points=5, three eat_ticks, model converter returns 16'h0015 -> score=15, high_score=15, exactly one new_high pulse per increase, disp_bcd=16'h0015.
REQ-040 Scenario: score=4093, eat_tick with points=9 -> score=4095 (saturated); then penalty_tick at score=0 -> score stays 0.
REQ-041 Scenario: simultaneous eat_tick (points=1) and penalty_tick -> score unchanged, dirty not set, no conv_en.
REQ-042 Scenario: score changes during WAIT, conv_rdy arrives -> disp_bcd holds the old value, then exactly one new conv_en with conv_bin equal to the latest score.
REQ-043 Scenario: converter never responds -> FSM returns to IDLE after 127 WAIT cycles and conv_en re-asserts 1 cycle later; disp_bcd unchanged.
REQ-044 Scenario: score=42, high_score=80, clear -> score=0, high_score=80, disp_bcd reaches 16'h0000 after conversion.
